// File: rtl/contador_bcd_cascata.sv
// Cascaded up/down modulo-MOD digit counter with parallel load, terminal-count flag and wrap pulse.
// Define CONTADOR_SATURATE_EN to hold at the end of range instead of wrapping.
module contador_bcd_cascata #(
    parameter int DIGITS = 2,
    parameter int MOD    = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] out,
    output logic                tc,
    output logic                wrap
);
    localparam logic [3:0] DMAX = 4'(MOD - 1);
    localparam logic [4:0] DMOD = 5'(MOD);

    logic                all_max;
    logic                all_zero;
    logic                at_end;
    logic [4*DIGITS-1:0] cnt_next;
    logic [4*DIGITS-1:0] load_clamped;

    always_comb begin
        all_max  = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (out[4*i +: 4] != DMAX) all_max = 1'b0;
            if (out[4*i +: 4] != 4'd0) all_zero = 1'b0;
        end
    end

    assign at_end = up ? all_max : all_zero;
    assign tc     = en & at_end;

    // Ripple enable: a digit steps only while every lower digit sits at its turnover value.
    always_comb begin : step_chain
        logic       carry;
        logic [3:0] d;
        carry    = 1'b1;
        d        = 4'd0;
        cnt_next = out;
        for (int i = 0; i < DIGITS; i++) begin
            d = out[4*i +: 4];
            if (carry) begin
                if (up) cnt_next[4*i +: 4] = (d == DMAX) ? 4'd0 : d + 4'd1;
                else    cnt_next[4*i +: 4] = (d == 4'd0) ? DMAX : d - 4'd1;
            end
            carry = carry & (up ? (d == DMAX) : (d == 4'd0));
        end
    end

    always_comb begin
        load_clamped = load_val;
        for (int i = 0; i < DIGITS; i++) begin
            if ({1'b0, load_val[4*i +: 4]} >= DMOD) load_clamped[4*i +: 4] = DMAX;
        end
    end

`ifdef CONTADOR_SATURATE_EN
    always_ff @(posedge clk) begin
        if (reset)                out <= '0;
        else if (load)            out <= load_clamped;
        else if (en && !at_end)   out <= cnt_next;
    end

    assign wrap = 1'b0;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            out  <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            out  <= load_clamped;
            wrap <= 1'b0;
        end else if (en) begin
            out  <= cnt_next;
            wrap <= at_end;
        end else begin
            wrap <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_contador_bcd_cascata.sv
// Directed bench: 2-digit decimal instance and a 3-digit modulo-6 instance, shared clock and reset.
module tb_contador_bcd_cascata;
`ifdef CONTADOR_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        en, up, load;
    logic [7:0]  load_val;
    logic [7:0]  a_out;
    logic        a_tc, a_wrap;
    logic        b_en, b_up, b_load;
    logic [11:0] b_load_val;
    logic [11:0] b_out;
    logic        b_tc, b_wrap;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    contador_bcd_cascata #(.DIGITS(2), .MOD(10)) dut_a (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .out(a_out), .tc(a_tc), .wrap(a_wrap)
    );

    contador_bcd_cascata #(.DIGITS(3), .MOD(6)) dut_b (
        .clk(clk), .reset(reset), .en(b_en), .up(b_up), .load(b_load),
        .load_val(b_load_val), .out(b_out), .tc(b_tc), .wrap(b_wrap)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [7:0] bcd2(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    initial begin
        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
        b_en = 1'b0; b_up = 1'b1; b_load = 1'b0; b_load_val = 12'h000;
        @(negedge clk);
        tick();
        check("rst_out", 32'(a_out), 32'h00);
        check("rst_wrap", 32'(a_wrap), 32'h0);
        check("rst_tc", 32'(a_tc), 32'h0);
        check("rst_b_out", 32'(b_out), 32'h000);

        // Full up sweep 00..99
        reset = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 100; i++) begin
            check("up_out", 32'(a_out), 32'(bcd2(i)));
            check("up_tc", 32'(a_tc), 32'(i == 99));
            if (i > 0) check("up_wrap", 32'(a_wrap), 32'h0);
            tick();
        end
        check("up_end_out", 32'(a_out), SAT ? 32'h99 : 32'h00);
        check("up_end_wrap", 32'(a_wrap), SAT ? 32'h0 : 32'h1);

        // From 99, five more up steps: wrap then continue, or hold when saturating
        load = 1'b1; load_val = 8'h99; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("end_out", 32'(a_out), SAT ? 32'h99 : 32'(bcd2(k)));
            check("end_wrap", 32'(a_wrap), (!SAT && k == 0) ? 32'h1 : 32'h0);
        end
        check("end_tc", 32'(a_tc), SAT ? 32'h1 : 32'h0);
        en = 1'b0;
        tick();
        check("idle_out", 32'(a_out), SAT ? 32'h99 : 32'h04);
        check("idle_wrap", 32'(a_wrap), 32'h0);
        check("idle_tc", 32'(a_tc), 32'h0);

        // Load 10 and count down through 00 to 99
        load = 1'b1; load_val = 8'h10;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0;
        check("dn_load", 32'(a_out), 32'h10);
        check("dn_tc0", 32'(a_tc), 32'h0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("dn_out", 32'(a_out), 32'(bcd2(10 - k)));
            check("dn_wrap", 32'(a_wrap), 32'h0);
        end
        check("dn_tc", 32'(a_tc), 32'h1);
        tick();
        check("dn_end_out", 32'(a_out), SAT ? 32'h00 : 32'h99);
        check("dn_end_wrap", 32'(a_wrap), SAT ? 32'h0 : 32'h1);

        // Load has priority over en and clamps each digit
        load = 1'b1; up = 1'b1; load_val = 8'hFA;
        tick();
        check("clamp_fa", 32'(a_out), 32'h99);
        check("clamp_wrap", 32'(a_wrap), 32'h0);
        load_val = 8'hA5;
        tick();
        check("clamp_a5", 32'(a_out), 32'h95);
        load_val = 8'h3C;
        tick();
        check("clamp_3c", 32'(a_out), 32'h39);

        // Reset mid-count, with load asserted, then resume
        load_val = 8'h47;
        tick();
        load = 1'b0;
        tick();
        check("pre_rst", 32'(a_out), 32'h48);
        reset = 1'b1; load = 1'b1; load_val = 8'h33;
        #1;
        check("rst_sync_hold", 32'(a_out), 32'h48);
        @(negedge clk);
        check("rst_mid_out", 32'(a_out), 32'h00);
        check("rst_mid_wrap", 32'(a_wrap), 32'h0);
        reset = 1'b0; load = 1'b0;
        tick();
        check("resume", 32'(a_out), 32'h01);
        up = 1'b0;
        tick();
        check("dir_flip", 32'(a_out), 32'h00);
        en = 1'b0;

        // Three digits, modulus 6
        b_load = 1'b1; b_load_val = 12'h555;
        tick();
        check("b_load", 32'(b_out), 32'h555);
        b_load = 1'b0; b_en = 1'b1; b_up = 1'b1;
        check("b_tc", 32'(b_tc), 32'h1);
        tick();
        check("b_wrap_out", 32'(b_out), SAT ? 32'h555 : 32'h000);
        check("b_wrap", 32'(b_wrap), SAT ? 32'h0 : 32'h1);
        b_load = 1'b1; b_load_val = 12'h123;
        tick();
        b_load = 1'b0;
        tick();
        check("b_up", 32'(b_out), 32'h124);
        b_up = 1'b0;
        tick();
        check("b_toggle", 32'(b_out), 32'h123);
        tick();
        check("b_dn", 32'(b_out), 32'h122);
        b_load = 1'b1; b_load_val = 12'h100;
        tick();
        b_load = 1'b0;
        tick();
        check("b_borrow", 32'(b_out), 32'h055);
        b_load = 1'b1; b_load_val = 12'h9F7;
        tick();
        check("b_clamp", 32'(b_out), 32'h555);
        b_load = 1'b0; b_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/contador_bcd_cascata.md
CONTADOR_BCD_CASCATA -- requirements
Module: contador_bcd_cascata

Interface
REQ-001 The block SHALL have parameter DIGITS, default 2, giving the number of cascaded digits (1..8).
REQ-002 The block SHALL have parameter MOD, default 10, giving the per-digit modulus (2..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port up, input, 1 bit: direction; 1 = increment, 0 = decrement.
REQ-007 The block SHALL have port load, input, 1 bit: parallel load strobe.
REQ-008 The block SHALL have port load_val, input, 4*DIGITS bits: parallel load value, digit i in bits [4i+3:4i].
REQ-009 The block SHALL have port out, output, 4*DIGITS bits: registered count, digit 0 least significant.
REQ-010 The block SHALL have port tc, output, 1 bit: combinational terminal-count flag.
REQ-011 The block SHALL have port wrap, output, 1 bit: registered one-cycle pulse after a wrap-around.

Function
REQ-012 Input priority at each rising clk edge SHALL be reset > load > en; with none active, out and wrap SHALL hold, except that wrap SHALL clear.
REQ-013 On load, each digit SHALL take its load_val field, clamped to MOD-1 when the field is >= MOD; wrap SHALL be 0 in that cycle.
REQ-014 With en=1 and up=1, digit i SHALL increment only when all lower digits equal MOD-1; digit 0 always steps; a stepping digit at MOD-1 SHALL become 0.
REQ-015 With en=1 and up=0, digit i SHALL decrement only when all lower digits equal 0; a stepping digit at 0 SHALL become MOD-1.
REQ-016 Each count step SHALL have 1-cycle latency: out reflects the step on the edge where en is sampled high.
REQ-017 tc SHALL equal en AND (up ? all digits == MOD-1 : all digits == 0), combinationally from the current out.
REQ-018 wrap SHALL be set for exactly one cycle following an edge where the full count moved from all-(MOD-1) to all-0 (up) or from all-0 to all-(MOD-1) (down).
REQ-019 Changing up between cycles SHALL take effect on the next edge with no extra cycle and no skipped value.
REQ-020 Unused digit codes (>= MOD) SHALL never appear on out.
REQ-021 load and en asserted together SHALL perform only the load; no count step occurs that cycle.

Reset
REQ-022 On reset=1 at a rising clk edge, out SHALL be all zeros and wrap SHALL be 0, regardless of load and en.
REQ-023 Reset asserted mid-count SHALL take effect on that edge; counting SHALL resume from 0 on the first edge after reset deasserts with en=1.
REQ-024 Reset SHALL have no asynchronous effect; between edges, out SHALL hold.

Configuration
REQ-025 Macro CONTADOR_SATURATE_EN SHALL select end-of-range behaviour.
REQ-026 With CONTADOR_SATURATE_EN defined, counting up at all-(MOD-1) or down at all-0 SHALL hold out unchanged, and wrap SHALL be held at constant 0; tc SHALL behave as in REQ-017.
REQ-027 Without CONTADOR_SATURATE_EN, the counter SHALL wrap per REQ-014, REQ-015 and REQ-018.

Verification (DIGITS=2, MOD=10 unless stated)
REQ-028 Apply reset, then en=1, up=1 for 100 cycles -> out steps 0x00..0x99, then 0x00; tc=1 while out=0x99; wrap=1 one cycle after 0x99->0x00.
REQ-029 load=1, load_val=0x10, then en=1, up=0 for 11 cycles -> out 0x10, 0x09, ..., 0x00, 0x99; wrap pulses after 0x00->0x99.
REQ-030 load_val=0xFA with load=1 and en=1 in the same cycle -> out=0x99 (clamped), no step that cycle.
REQ-031 At out=0x47 with en=1, assert reset with load=1 -> out=0x00 on that edge, wrap=0.
REQ-032 With CONTADOR_SATURATE_EN defined, at out=0x99 with en=1, up=1 for 5 cycles -> out stays 0x99, tc=1, wrap=0.
REQ-033 DIGITS=3, MOD=6: count up from 0x555 -> out=0x000, wrap pulse; toggle up at 0x123 -> next value 0x122.
